// File: rtl/timer_display.sv
// Display stage for the countdown timer: converts the remaining seconds to two
// 7-segment digits (active-low) with a subtract-by-ten FSM and blinks them once done.
module timer_display #(
    parameter int BLINK_HALF = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] t,
    input  logic       done,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int PW = $clog2(BLINK_HALF);
    localparam logic [PW-1:0] PMAX = PW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        UPD  = 3'd2
    } state_t;

    state_t        state;
    logic [7:0]    work;
    logic [7:0]    cap;
    logic [7:0]    shown;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [6:0]    dt;
    logic [6:0]    dig_o;
    logic          force_cap;
    logic          ovf;
    logic [PW-1:0] pcnt;
    logic          vis;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // cap keeps the captured t because work is consumed by the conversion;
    // digits only change in UPD, so partial results never reach the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= 8'd0;
            cap       <= 8'd0;
            shown     <= 8'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            dt        <= 7'h7F;
            dig_o     <= 7'h7F;
            force_cap <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (force_cap || (t != shown)) begin
                        work      <= t;
                        cap       <= t;
                        tens      <= 4'd0;
                        ovf       <= (t > 8'd99);
                        force_cap <= 1'b0;
                        state     <= (t > 8'd99) ? UPD : CONV;
                    end
                end
                CONV: begin
                    if (work >= 8'd10) begin
                        work <= work - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        ones  <= work[3:0];
                        state <= UPD;
                    end
                end
                UPD: begin
                    if (ovf) begin
                        dt    <= 7'h3F;
                        dig_o <= 7'h3F;
                    end else begin
                        dt    <= seg_code(tens);
                        dig_o <= seg_code(ones);
                    end
                    shown <= cap;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Blink phase restarts visible whenever done is low.
    always_ff @(posedge clk) begin
        if (rst || !done) begin
            pcnt <= '0;
            vis  <= 1'b1;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
            vis  <= ~vis;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign seg_tens  = vis ? dt    : 7'h7F;
    assign seg_ones  = vis ? dig_o : 7'h7F;
    assign busy      = (state == CONV) || (state == UPD);
    assign dbg_state = state;

endmodule

// File: tb/tb_timer_display.sv
// Randomized bench for timer_display against an arithmetic model of the
// display latency (t/10 + 2 edges, or 1 edge for overflow) and the blink rule.
module tb_timer_display;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [7:0] t;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic       busy;
    logic [2:0] dbg_state;

    timer_display #(.BLINK_HALF(BH)) dut (
        .clk       (clk),
        .rst       (rst),
        .t         (t),
        .done      (done),
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: edges left until the display update, the captured value, blink phase.
    int         m_rem;
    int         m_pcnt;
    logic [7:0] m_cap;
    logic [7:0] m_shown;
    logic       m_force;
    logic       m_vis;
    logic [6:0] m_dt;
    logic [6:0] m_do;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] tv, input logic dv, input logic rv);
        if (rv) begin
            m_rem = 0; m_force = 1'b1; m_shown = 8'd0; m_cap = 8'd0;
            m_dt = 7'h7F; m_do = 7'h7F; m_vis = 1'b1; m_pcnt = 0;
        end else begin
            if (m_rem == 0) begin
                if (m_force || tv != m_shown) begin
                    m_cap   = tv;
                    m_force = 1'b0;
                    m_rem   = (tv > 99) ? 1 : int'(tv) / 10 + 2;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_cap > 99) begin
                        m_dt = 7'h3F; m_do = 7'h3F;
                    end else begin
                        m_dt = seg_lut[int'(m_cap) / 10];
                        m_do = seg_lut[int'(m_cap) % 10];
                    end
                    m_shown = m_cap;
                end
            end
            if (dv) begin
                if (m_pcnt == BH - 1) begin
                    m_pcnt = 0; m_vis = !m_vis;
                end else begin
                    m_pcnt++;
                end
            end else begin
                m_pcnt = 0; m_vis = 1'b1;
            end
        end
        exp_q.push_back({(m_rem > 0), (m_vis ? m_dt : 7'h7F), (m_vis ? m_do : 7'h7F)});
    endtask

    task automatic cycle(input logic [7:0] tv, input logic dv, input logic rv);
        logic [14:0] e;
        t = tv; done = dv; rst = rv;
        @(posedge clk);
        model_step(tv, dv, rv);
        #1;
        e = exp_q.pop_front();
        check("busy", busy, e[14]);
        check("seg_tens", seg_tens, e[13:7]);
        check("seg_ones", seg_ones, e[6:0]);
        check("state_idle", (dbg_state == 3'd0), !e[14]);
    endtask

    initial begin
        logic [7:0] tv;
        logic       dv;
        int         n;

        // Reset with t=60, then a full conversion.
        repeat (3) cycle(8'd60, 1'b0, 1'b1);
        repeat (12) cycle(8'd60, 1'b0, 1'b0);
        repeat (10) cycle(8'd59, 1'b0, 1'b0);
        repeat (5) cycle(8'd7, 1'b0, 1'b0);
        repeat (5) cycle(8'd0, 1'b0, 1'b0);
        // Overflow then worst-case conversion.
        repeat (4) cycle(8'd150, 1'b0, 1'b0);
        repeat (14) cycle(8'd99, 1'b0, 1'b0);
        // Change during conversion.
        repeat (2) cycle(8'd60, 1'b0, 1'b0);
        repeat (20) cycle(8'd45, 1'b0, 1'b0);
        // Blink, then drop done while blanked.
        repeat (6) cycle(8'd0, 1'b0, 1'b0);
        repeat (13) cycle(8'd0, 1'b1, 1'b0);
        repeat (3) cycle(8'd0, 1'b0, 1'b0);
        repeat (9) cycle(8'd0, 1'b1, 1'b0);
        repeat (3) cycle(8'd0, 1'b0, 1'b0);
        // Reset mid-conversion of 99.
        repeat (4) cycle(8'd99, 1'b0, 1'b0);
        cycle(8'd99, 1'b0, 1'b1);
        repeat (14) cycle(8'd99, 1'b0, 1'b0);

        // Random stimulus.
        dv = 1'b0;
        repeat (150) begin
            tv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255))
                                             : 8'($urandom_range(0, 99));
            n = $urandom_range(1, 25);
            if ($urandom_range(0, 3) == 0) dv = !dv;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) tv = 8'($urandom_range(0, 255));
                cycle(tv, dv, ($urandom_range(0, 60) == 0));
            end
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
